tick_scheduler: RTL and testbench

//  Multi-channel event scheduler driven by the free-running prescaler taps. Each channel picks one tap,

---
 rtl/tick_scheduler_pkg.sv | 18 +
 rtl/tick_scheduler_if.sv | 36 +++
 rtl/tick_scheduler_chan.sv | 106 ++++++++++
 rtl/tick_scheduler.sv | 92 +++++++++
 tb/tb_tick_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tick_scheduler_pkg.sv
// Shared types and constants for the tick scheduler: channel states, run modes
// and an index-width helper.
package tick_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } chan_state_t;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tick_scheduler_if.sv
// Configuration, control and strobe bundle of the tick scheduler.
interface tick_scheduler_if
   import tick_scheduler_pkg::*;
#(
   parameter int unsigned NCH  = 4,
   parameter int unsigned TAPS = 8,
   parameter int unsigned SELW = 3,
   parameter int unsigned CW   = 8
) ();

   localparam int unsigned CHW = idx_width(NCH);

   logic [TAPS-1:0] taps;
   logic            cfg_we;
   logic [CHW-1:0]  cfg_ch;
   logic [SELW-1:0] cfg_sel;
   logic            cfg_mode;
   logic [CW-1:0]   cfg_div;
   logic [NCH-1:0]  start;
   logic [NCH-1:0]  stop;
   logic [NCH-1:0]  tick;
   logic [NCH-1:0]  busy;
   logic [NCH-1:0]  done;
   logic            cfg_err;

   modport master (
      output taps, cfg_we, cfg_ch, cfg_sel, cfg_mode, cfg_div, start, stop,
      input  tick, busy, done, cfg_err
   );

   modport slave (
      input  taps, cfg_we, cfg_ch, cfg_sel, cfg_mode, cfg_div, start, stop,
      output tick, busy, done, cfg_err
   );

endinterface

// File: rtl/tick_scheduler_chan.sv
// One scheduler channel: config registers, edge counter and IDLE/RUN/DONE FSM.
module tick_sched_chan
   import tick_scheduler_pkg::*;
#(
   parameter int unsigned SELW = 3,
   parameter int unsigned CW   = 8
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            rise,
   input  logic            start,
   input  logic            stop,
   input  logic            wr,
   input  logic [SELW-1:0] wr_sel,
   input  logic            wr_mode,
   input  logic [CW-1:0]   wr_div,
   output logic [SELW-1:0] sel,
   output logic            tick,
   output logic            busy,
   output logic            done,
   output logic            err
);

   chan_state_t     state, state_d;
   logic [SELW-1:0] sel_d;
   logic            mode, mode_d;
   logic [CW-1:0]   div, div_d;
   logic [CW-1:0]   cnt, cnt_d;
   logic            tick_d;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         sel   <= '0;
         mode  <= MODE_ONESHOT;
         div   <= CW'(1);
         cnt   <= '0;
         tick  <= 1'b0;
      end else begin
         state <= state_d;
         sel   <= sel_d;
         mode  <= mode_d;
         div   <= div_d;
         cnt   <= cnt_d;
         tick  <= tick_d;
      end
   end

   // A write accepted this cycle is visible to a same-cycle start through div_d.
   always_comb begin
      state_d = state;
      sel_d   = sel;
      mode_d  = mode;
      div_d   = div;
      cnt_d   = cnt;
      tick_d  = 1'b0;
      err     = 1'b0;
      if (wr) begin
         if (state == ST_IDLE) begin
            sel_d  = wr_sel;
            mode_d = wr_mode;
            div_d  = wr_div;
         end else begin
            err = 1'b1;
         end
      end
      unique case (state)
         ST_IDLE: begin
            if (start && !stop) begin
               if (div_d == '0) begin
                  err = 1'b1;
               end else begin
                  state_d = ST_RUN;
                  cnt_d   = div_d;
               end
            end
         end
         ST_RUN: begin
            if (rise) begin
               if (cnt == CW'(1)) begin
                  tick_d = 1'b1;
                  if (mode == MODE_PERIODIC) begin
                     cnt_d = div;
                  end else begin
                     state_d = ST_DONE;
                     cnt_d   = '0;
                  end
               end else begin
                  cnt_d = cnt - CW'(1);
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (stop) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         tick_d  = 1'b0;
      end
   end

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_DONE);

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel tick scheduler: tap edge detect, per-channel tap mux, config decode.
// Define TICK_SCHED_SYNC_EN to pass taps through a 2-flop synchronizer (+2 cycles latency).
module tick_scheduler
   import tick_scheduler_pkg::*;
#(
   parameter int unsigned NCH  = 4,
   parameter int unsigned TAPS = 8,
   parameter int unsigned SELW = 3,
   parameter int unsigned CW   = 8
) (
   input logic             clk,
   input logic             reset_n,
   tick_scheduler_if.slave bus
);

   localparam int unsigned CHW  = idx_width(NCH);
   localparam int unsigned SELN = 2**SELW;

   logic [TAPS-1:0] taps_s, taps_q, rise;
   logic [SELN-1:0] rise_ext;
   logic            cfg_bad, cfg_err_q;
   logic [NCH-1:0]  wr, chan_err, tick_v, busy_v, done_v;
   logic [SELW-1:0] sel_v [NCH];

`ifdef TICK_SCHED_SYNC_EN
   logic [TAPS-1:0] sync1, sync2;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= bus.taps;
         sync2 <= sync1;
      end
   end

   assign taps_s = sync2;
`else
   assign taps_s = bus.taps;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         taps_q    <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         taps_q    <= taps_s;
         cfg_err_q <= cfg_bad || (|chan_err);
      end
   end

   assign rise = taps_s & ~taps_q;

   // Pad to the full select range so every sel value indexes a real bit.
   always_comb begin
      rise_ext           = '0;
      rise_ext[TAPS-1:0] = rise;
   end

   assign cfg_bad = bus.cfg_we && ((32'(bus.cfg_sel) >= TAPS) || (bus.cfg_div == '0));

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      assign wr[i] = bus.cfg_we && !cfg_bad && (bus.cfg_ch == CHW'(i));

      tick_sched_chan #(
         .SELW (SELW),
         .CW   (CW)
      ) u_chan (
         .clk     (clk),
         .reset_n (reset_n),
         .rise    (rise_ext[sel_v[i]]),
         .start   (bus.start[i]),
         .stop    (bus.stop[i]),
         .wr      (wr[i]),
         .wr_sel  (bus.cfg_sel),
         .wr_mode (bus.cfg_mode),
         .wr_div  (bus.cfg_div),
         .sel     (sel_v[i]),
         .tick    (tick_v[i]),
         .busy    (busy_v[i]),
         .done    (done_v[i]),
         .err     (chan_err[i])
      );
   end

   assign bus.tick    = tick_v;
   assign bus.busy    = busy_v;
   assign bus.done    = done_v;
   assign bus.cfg_err = cfg_err_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler: vector table, directed corner sequences
// and randomized tap traffic against an edge-list reference model.
module tb_tick_scheduler;

   localparam int NCH  = 4;
   localparam int TAPS = 6;
   localparam int SELW = 3;
   localparam int CW   = 8;
   localparam int CHW  = 2;
   localparam int L    = 64;
`ifdef TICK_SCHED_SYNC_EN
   localparam int D = 2;
`else
   localparam int D = 0;
`endif
   localparam int LAT = D + 1;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   tick_scheduler_if #(.NCH(NCH), .TAPS(TAPS), .SELW(SELW), .CW(CW)) bus ();

   tick_scheduler #(.NCH(NCH), .TAPS(TAPS), .SELW(SELW), .CW(CW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      logic            we;
      logic [CHW-1:0]  ch;
      logic [SELW-1:0] sel;
      logic            mode;
      logic [CW-1:0]   div;
      logic [NCH-1:0]  start;
      logic [NCH-1:0]  stop;
      logic            exp_err;
      logic [NCH-1:0]  exp_busy;
   } vec_t;

   vec_t tbl[13];

   int n_total = 0;
   int n_pass  = 0;

   logic [TAPS-1:0] tv   [0:L];
   logic [NCH-1:0]  et_a [0:L];
   logic [NCH-1:0]  ed_a [0:L];
   logic [NCH-1:0]  eb_a [0:L];
   int              ts   [NCH];
   int              rsel [NCH];
   int              rdiv [NCH];
   int              rmode[NCH];
   logic [NCH-1:0]  smask;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input int ch, input int sel, input int mode, input int div,
                      input logic [NCH-1:0] st);
      bus.cfg_we   = 1'b1;
      bus.cfg_ch   = CHW'(ch);
      bus.cfg_sel  = SELW'(sel);
      bus.cfg_mode = mode[0];
      bus.cfg_div  = CW'(div);
      bus.start    = st;
      step();
      bus.cfg_we = 1'b0;
      bus.start  = '0;
      check("cfg_err_ok", bus.cfg_err, 0);
   endtask

   task automatic start_ch(input logic [NCH-1:0] m);
      bus.start = m;
      step();
      bus.start = '0;
      check("busy_after_start", bus.busy, m);
   endtask

   task automatic stop_ch(input logic [NCH-1:0] m);
      bus.stop = m;
      step();
      bus.stop = '0;
      check("busy_after_stop", bus.busy & m, 0);
   endtask

   // Pulse one tap for a cycle; tick/done must appear exactly LAT cycles later, for one cycle.
   task automatic edge_chk(input int b, input logic [NCH-1:0] et, input logic [NCH-1:0] ed,
                           input string nm);
      bus.taps[b] = 1'b1;
      for (int c = 1; c <= LAT; c++) begin
         step();
         if (c == 1) bus.taps[b] = 1'b0;
         if (c == LAT) begin
            check({nm, "_tick"}, bus.tick, et);
            check({nm, "_done"}, bus.done, ed);
         end else begin
            check({nm, "_early"}, bus.tick, 0);
         end
      end
      step();
      check({nm, "_tick_width"}, bus.tick, 0);
      check({nm, "_done_width"}, bus.done, 0);
   endtask

   initial begin
      reset_n      = 1'b0;
      bus.taps     = '0;
      bus.cfg_we   = 1'b0;
      bus.cfg_ch   = '0;
      bus.cfg_sel  = '0;
      bus.cfg_mode = 1'b0;
      bus.cfg_div  = '0;
      bus.start    = '0;
      bus.stop     = '0;

      // Vector table: inputs for one cycle, expected cfg_err/busy on the next.
      tbl[0]  = '{1'b1, 2'd1, 3'd2, 1'b1, 8'd1,   4'b0000, 4'b0000, 1'b0, 4'b0000};
      tbl[1]  = '{1'b0, 2'd0, 3'd0, 1'b0, 8'd0,   4'b0010, 4'b0000, 1'b0, 4'b0010};
      tbl[2]  = '{1'b1, 2'd1, 3'd3, 1'b0, 8'd5,   4'b0000, 4'b0000, 1'b1, 4'b0010};
      tbl[3]  = '{1'b1, 2'd0, 3'd1, 1'b0, 8'd0,   4'b0000, 4'b0000, 1'b1, 4'b0010};
      tbl[4]  = '{1'b1, 2'd0, 3'd6, 1'b0, 8'd2,   4'b0000, 4'b0000, 1'b1, 4'b0010};
      tbl[5]  = '{1'b1, 2'd0, 3'd7, 1'b0, 8'd2,   4'b0000, 4'b0000, 1'b1, 4'b0010};
      tbl[6]  = '{1'b1, 2'd0, 3'd5, 1'b0, 8'd2,   4'b0000, 4'b0000, 1'b0, 4'b0010};
      tbl[7]  = '{1'b0, 2'd0, 3'd0, 1'b0, 8'd0,   4'b0010, 4'b0000, 1'b0, 4'b0010};
      tbl[8]  = '{1'b1, 2'd2, 3'd5, 1'b0, 8'd255, 4'b0000, 4'b0000, 1'b0, 4'b0010};
      tbl[9]  = '{1'b0, 2'd0, 3'd0, 1'b0, 8'd0,   4'b0100, 4'b0010, 1'b0, 4'b0100};
      tbl[10] = '{1'b0, 2'd0, 3'd0, 1'b0, 8'd0,   4'b0000, 4'b0100, 1'b0, 4'b0000};
      tbl[11] = '{1'b0, 2'd0, 3'd0, 1'b0, 8'd0,   4'b1000, 4'b1000, 1'b0, 4'b0000};
      tbl[12] = '{1'b0, 2'd0, 3'd0, 1'b0, 8'd0,   4'b0000, 4'b0000, 1'b0, 4'b0000};

      // Reset held with taps toggling
      for (int i = 0; i < 3; i++) begin
         bus.taps = ~bus.taps;
         step();
         check("rst_tick", bus.tick, 0);
         check("rst_busy", bus.busy, 0);
         check("rst_done", bus.done, 0);
         check("rst_err", bus.cfg_err, 0);
      end
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.taps = ~bus.taps;
         step();
         check("idle_tick", bus.tick, 0);
         check("idle_busy", bus.busy, 0);
      end
      bus.taps = '0;
      for (int i = 0; i < D + 2; i++) step();

      for (int i = 0; i < 13; i++) begin
         bus.cfg_we   = tbl[i].we;
         bus.cfg_ch   = tbl[i].ch;
         bus.cfg_sel  = tbl[i].sel;
         bus.cfg_mode = tbl[i].mode;
         bus.cfg_div  = tbl[i].div;
         bus.start    = tbl[i].start;
         bus.stop     = tbl[i].stop;
         step();
         bus.cfg_we = 1'b0;
         bus.start  = '0;
         bus.stop   = '0;
         check($sformatf("tbl%0d_err", i), bus.cfg_err, tbl[i].exp_err);
         check($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].exp_busy);
         check($sformatf("tbl%0d_tick", i), bus.tick, 0);
      end

      // One-shot: div 3 on tap 0
      cfg(0, 0, 0, 3, 4'b0000);
      start_ch(4'b0001);
      edge_chk(0, 4'b0000, 4'b0000, "os_e1");
      edge_chk(0, 4'b0000, 4'b0000, "os_e2");
      edge_chk(0, 4'b0001, 4'b0001, "os_e3");
      check("os_busy_end", bus.busy, 0);

      // Periodic: div 1 on tap 2, then stop
      cfg(1, 2, 1, 1, 4'b0000);
      start_ch(4'b0010);
      for (int i = 0; i < 5; i++) begin
         edge_chk(2, 4'b0010, 4'b0000, "per");
         check("per_busy", bus.busy, 4'b0010);
      end
      stop_ch(4'b0010);
      edge_chk(2, 4'b0000, 4'b0000, "per_after_stop");

      // Rejected write to a running channel leaves its config intact
      cfg(1, 2, 1, 2, 4'b0000);
      start_ch(4'b0010);
      bus.cfg_we  = 1'b1;
      bus.cfg_ch  = 2'd1;
      bus.cfg_sel = 3'd4;
      bus.cfg_div = 8'd1;
      step();
      bus.cfg_we = 1'b0;
      check("run_wr_err", bus.cfg_err, 1);
      step();
      check("run_wr_err_width", bus.cfg_err, 0);
      edge_chk(4, 4'b0000, 4'b0000, "keep_sel4a");
      edge_chk(4, 4'b0000, 4'b0000, "keep_sel4b");
      edge_chk(2, 4'b0000, 4'b0000, "keep_div1");
      edge_chk(2, 4'b0010, 4'b0000, "keep_div2");
      stop_ch(4'b0010);

      // Stop collides with the final edge of a one-shot
      cfg(0, 0, 0, 2, 4'b0000);
      start_ch(4'b0001);
      edge_chk(0, 4'b0000, 4'b0000, "col_e1");
      bus.taps[0] = 1'b1;
      for (int c = 0; c <= D; c++) begin
         if (c == D) bus.stop = 4'b0001;
         step();
         bus.taps[0] = 1'b0;
         bus.stop    = '0;
      end
      check("col_busy", bus.busy, 0);
      for (int c = 0; c < LAT + 1; c++) begin
         check("col_tick", bus.tick, 0);
         check("col_done", bus.done, 0);
         step();
      end

      // Config write and start in the same cycle
      cfg(2, 1, 0, 2, 4'b0100);
      check("wrst_busy", bus.busy, 4'b0100);
      edge_chk(1, 4'b0000, 4'b0000, "wrst_e1");
      edge_chk(1, 4'b0100, 4'b0100, "wrst_e2");
      check("wrst_busy_end", bus.busy, 0);

      // All channels on one tap
      for (int ch = 0; ch < NCH; ch++) cfg(ch, 3, 1, 1, 4'b0000);
      start_ch(4'b1111);
      for (int i = 0; i < 3; i++) edge_chk(3, 4'b1111, 4'b0000, "conc");
      stop_ch(4'b1111);

      // Reset mid-run, then defaults (sel 0, div 1, one-shot) apply
      cfg(1, 2, 1, 1, 4'b0000);
      start_ch(4'b0010);
      reset_n     = 1'b0;
      bus.taps[2] = 1'b1;
      step();
      reset_n     = 1'b1;
      bus.taps[2] = 1'b0;
      check("mr_busy", bus.busy, 0);
      check("mr_done", bus.done, 0);
      for (int c = 0; c < LAT + 1; c++) begin
         check("mr_tick", bus.tick, 0);
         step();
      end
      start_ch(4'b1000);
      edge_chk(0, 4'b1000, 4'b1000, "mr_default");
      check("mr_busy_end", bus.busy, 0);

      // Randomized rounds against the edge-list model
      for (int r = 0; r < 12; r++) begin
         for (int ch = 0; ch < NCH; ch++) begin
            rsel[ch]  = $urandom_range(0, TAPS - 1);
            rdiv[ch]  = $urandom_range(1, 4);
            rmode[ch] = $urandom_range(0, 1);
            cfg(ch, rsel[ch], rmode[ch], rdiv[ch], 4'b0000);
         end
         for (int i = 0; i < D + 2; i++) step();
         smask = NCH'($urandom_range(1, 15));
         for (int ch = 0; ch < NCH; ch++)
            ts[ch] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, L - 7) : L - 2;
         tv[0] = bus.taps;
         for (int k = 0; k < L; k++)
            tv[k + 1] = (k <= L - 6) ? TAPS'($urandom) : tv[L - 5];
         for (int k = 0; k <= L; k++) begin
            et_a[k] = '0;
            ed_a[k] = '0;
            eb_a[k] = '0;
         end
         // Every div-th counted edge ticks one cycle after the edge reaches the channel.
         for (int ch = 0; ch < NCH; ch++) begin
            if (smask[ch]) begin
               int cnt;
               int last;
               int e;
               bit fin;
               cnt  = 0;
               last = ts[ch];
               fin  = 1'b0;
               for (int n = 0; n < L; n++) begin
                  e = n + D;
                  if (!fin && tv[n + 1][rsel[ch]] && !tv[n][rsel[ch]] && e >= 1 && e < ts[ch]) begin
                     cnt++;
                     if (cnt % rdiv[ch] == 0) begin
                        et_a[e + 1][ch] = 1'b1;
                        if (rmode[ch] == 0) begin
                           ed_a[e + 1][ch] = 1'b1;
                           fin  = 1'b1;
                           last = e + 1;
                        end
                     end
                  end
               end
               for (int k = 1; k <= last; k++) eb_a[k][ch] = 1'b1;
            end
         end
         for (int k = 0; k < L; k++) begin
            bus.taps  = tv[k + 1];
            bus.start = (k == 0) ? smask : '0;
            for (int ch = 0; ch < NCH; ch++) bus.stop[ch] = (ts[ch] == k);
            step();
            check($sformatf("rnd%0d_c%0d_tick", r, k + 1), bus.tick, et_a[k + 1]);
            check($sformatf("rnd%0d_c%0d_done", r, k + 1), bus.done, ed_a[k + 1]);
            check($sformatf("rnd%0d_c%0d_busy", r, k + 1), bus.busy, eb_a[k + 1]);
            check($sformatf("rnd%0d_c%0d_err", r, k + 1), bus.cfg_err, 0);
         end
         bus.start = '0;
         bus.stop  = '0;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
